// File: rtl/sw_row_feeder_if.sv
// Search-window row feeder bus bundle.
// Groups the reference-pixel input handshake and the row output stream.
//   in_data  : 8 reference pixels per beat, pixel 0 in bits [63:56]
//   in_valid : in_data valid this cycle
//   in_ready : feeder accepts a beat this cycle
//   sw_row   : one search-window row, leftmost pixel in MSBs
//   sw_valid : sw_row valid this cycle
//   sw_first : marks row 0 of a window
//   sw_last  : marks the last row of a window
// master = pixel source / row consumer side, slave = the feeder itself.
interface sw_row_feeder_if #(
  parameter int ROW_W = 184
);
  logic [63:0]      in_data;
  logic             in_valid;
  logic             in_ready;
  logic [ROW_W-1:0] sw_row;
  logic             sw_valid;
  logic             sw_first;
  logic             sw_last;

  modport master (
    output in_data, in_valid,
    input  in_ready, sw_row, sw_valid, sw_first, sw_last
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, sw_row, sw_valid, sw_first, sw_last
  );
endinterface

// File: rtl/sw_row_feeder.sv
// Search-window row feeder.
// Collects ROWS rows of reference pixels (three 64-bit beats per row) into a
// row buffer, then streams the whole window out as ROWS back-to-back rows.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : sw_row_feeder_if slave modport (input beats in, window rows out)
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | one cycle after reset; counters cleared, input not accepted
// FILL  | accepting beats, assembling rows into the row buffer
// BURST | streaming buffer entries 0..ROWS-1, one per cycle, no input
module sw_row_feeder #(
  parameter int PIX_W   = 8,
  parameter int ROW_PIX = 23,
  parameter int ROWS    = 23
) (
  input  logic           clk,
  input  logic           rst,
  sw_row_feeder_if.slave bus
);
  localparam int ROW_W = ROW_PIX * PIX_W;
  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

  typedef enum logic [1:0] {IDLE, FILL, BURST} state_t;

  state_t           state, state_d;
  logic [1:0]       word_cnt, word_cnt_d;
  logic [RW-1:0]    row_cnt, row_cnt_d;
  logic [RW-1:0]    rd_idx, rd_idx_d;
  logic [63:0]      w0, w1;
  logic [ROW_W-1:0] row_buf [ROWS];
  logic [191:0]     cat;
  logic [ROW_W-1:0] asm_row;
  logic             accept;
  logic             row_done;
  logic             unused_tail;

  logic             in_ready_q, in_ready_d;
  logic             sw_valid_q, sw_valid_d;
  logic             sw_first_q, sw_first_d;
  logic             sw_last_q,  sw_last_d;
  logic [ROW_W-1:0] sw_row_q,   sw_row_d;

  // The row keeps the top ROW_W bits of the three beats; the last pixel of w2 is dropped.
  assign cat         = {w0, w1, bus.in_data};
  assign asm_row     = cat[191 -: ROW_W];
  assign unused_tail = ^cat[191-ROW_W:0];

  assign accept   = (state == FILL) && bus.in_valid;
  assign row_done = accept && (word_cnt == 2'd2);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d    = state;
    word_cnt_d = word_cnt;
    row_cnt_d  = row_cnt;
    rd_idx_d   = rd_idx;
    in_ready_d = 1'b0;
    sw_valid_d = 1'b0;
    sw_first_d = 1'b0;
    sw_last_d  = 1'b0;
    sw_row_d   = '0;
    case (state)
      IDLE: begin
        state_d    = FILL;
        word_cnt_d = 2'd0;
        row_cnt_d  = '0;
        rd_idx_d   = '0;
        in_ready_d = 1'b1;
      end
      FILL: begin
        in_ready_d = 1'b1;
        if (accept) begin
          if (word_cnt == 2'd2) begin
            word_cnt_d = 2'd0;
            if (row_cnt == LAST_ROW) begin
              // Window complete: row 0 goes out on the very next cycle.
              row_cnt_d  = '0;
              rd_idx_d   = '0;
              state_d    = BURST;
              in_ready_d = 1'b0;
              sw_valid_d = 1'b1;
              sw_first_d = 1'b1;
              sw_last_d  = (ROWS == 1);
              // A one-row window has its only row still in flight to the buffer.
              sw_row_d   = (ROWS == 1) ? asm_row : row_buf[0];
            end else begin
              row_cnt_d = row_cnt + RW'(1);
            end
          end else begin
            word_cnt_d = word_cnt + 2'd1;
          end
        end
      end
      BURST: begin
        if (rd_idx == LAST_ROW) begin
          state_d    = FILL;
          rd_idx_d   = '0;
          in_ready_d = 1'b1;
        end else begin
          rd_idx_d   = rd_idx + RW'(1);
          sw_valid_d = 1'b1;
          sw_last_d  = (rd_idx_d == LAST_ROW);
          sw_row_d   = row_buf[rd_idx_d];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word_cnt   <= 2'd0;
      row_cnt    <= '0;
      rd_idx     <= '0;
      in_ready_q <= 1'b0;
      sw_valid_q <= 1'b0;
      sw_first_q <= 1'b0;
      sw_last_q  <= 1'b0;
      sw_row_q   <= '0;
    end else begin
      word_cnt   <= word_cnt_d;
      row_cnt    <= row_cnt_d;
      rd_idx     <= rd_idx_d;
      in_ready_q <= in_ready_d;
      sw_valid_q <= sw_valid_d;
      sw_first_q <= sw_first_d;
      sw_last_q  <= sw_last_d;
      sw_row_q   <= sw_row_d;
    end
  end

  // Capture registers and row buffer carry no reset; a burst only follows a full fill.
  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      if (word_cnt == 2'd0) w0 <= bus.in_data;
      if (word_cnt == 2'd1) w1 <= bus.in_data;
    end
    if (!rst && row_done) row_buf[row_cnt] <= asm_row;
  end

  assign bus.in_ready = in_ready_q;
  assign bus.sw_valid = sw_valid_q;
  assign bus.sw_first = sw_first_q;
  assign bus.sw_last  = sw_last_q;
  assign bus.sw_row   = sw_row_q;
endmodule

// File: tb/tb_sw_row_feeder.sv
module tb_sw_row_feeder;
  localparam int PIX_W   = 8;
  localparam int ROW_PIX = 23;
  localparam int ROWS    = 23;
  localparam int ROW_W   = PIX_W * ROW_PIX;
  localparam int BEATS   = 3 * ROWS;

  typedef struct {
    logic [ROW_W-1:0] row;
    bit               first;
    bit               last;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sw_row_feeder_if #(.ROW_W(ROW_W)) bus ();

  sw_row_feeder #(.PIX_W(PIX_W), .ROW_PIX(ROW_PIX), .ROWS(ROWS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          compared   = 0;
  int          mismatched = 0;
  bit          post_reset;
  logic [63:0] beats [$];
  exp_t        expq [$];

  task automatic chk(input string tag, input logic [ROW_W-1:0] obs, input logic [ROW_W-1:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference: once a full window of accepted beats exists, its rows are due
  // on consecutive cycles starting with the next one.
  task automatic build_window();
    exp_t e;
    for (int r = 0; r < ROWS; r++) begin
      logic [63:0] b2;
      b2      = beats[3*r+2];
      e.row   = {beats[3*r], beats[3*r+1], b2[63:8]};
      e.first = (r == 0);
      e.last  = (r == ROWS - 1);
      expq.push_back(e);
    end
    beats.delete();
  endtask

  // Called at a negedge: check current outputs, drive the next beat, advance one cycle.
  task automatic tick(input bit v, input logic [63:0] d);
    bit   exp_ready;
    exp_t e;
    exp_ready = !post_reset && (expq.size() == 0);
    chk("in_ready", ROW_W'(bus.in_ready), ROW_W'(exp_ready));
    if (expq.size() > 0) begin
      e = expq.pop_front();
      chk("sw_valid", ROW_W'(bus.sw_valid), ROW_W'(1));
      chk("sw_row",   bus.sw_row, e.row);
      chk("sw_first", ROW_W'(bus.sw_first), ROW_W'(e.first));
      chk("sw_last",  ROW_W'(bus.sw_last),  ROW_W'(e.last));
    end else begin
      chk("idle_valid", ROW_W'(bus.sw_valid), ROW_W'(0));
      chk("idle_row",   bus.sw_row, '0);
      chk("idle_first", ROW_W'(bus.sw_first), ROW_W'(0));
      chk("idle_last",  ROW_W'(bus.sw_last),  ROW_W'(0));
    end
    bus.in_valid = v;
    bus.in_data  = d;
    if (v && exp_ready) begin
      beats.push_back(d);
      if (beats.size() == BEATS) build_window();
    end
    post_reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_valid", ROW_W'(bus.sw_valid), ROW_W'(0));
    chk("rst_ready", ROW_W'(bus.in_ready), ROW_W'(0));
    chk("rst_row",   bus.sw_row, '0);
    chk("rst_first", ROW_W'(bus.sw_first), ROW_W'(0));
    chk("rst_last",  ROW_W'(bus.sw_last),  ROW_W'(0));
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    beats.delete();
    expq.delete();
    post_reset = 1'b1;
  endtask

  function automatic logic [63:0] pat(input int k);
    logic [7:0] kb;
    kb = k[7:0];
    return {8{kb}};
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  initial begin
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    @(negedge clk);
    do_reset();

    // Idle after reset: nothing in, nothing out.
    for (int i = 0; i < 100; i++) tick(1'b0, '0);

    // Back-to-back fill with counting pattern, then drain.
    for (int k = 0; k < BEATS; k++) tick(1'b1, pat(k));
    for (int i = 0; i < ROWS + 3; i++) tick(1'b0, '0);

    // Gapped fill with the same pattern.
    for (int k = 0; k < BEATS; k++) begin
      tick(1'b1, pat(k));
      tick(1'b0, 64'hDEAD_BEEF_0000_0000);
    end

    // Hold all-ones valid through the burst; only post-burst beats may land.
    for (int i = 0; i < ROWS; i++) tick(1'b1, '1);
    for (int k = 0; k < BEATS; k++) tick(1'b1, rnd64());
    for (int i = 0; i < ROWS + 3; i++) tick(1'b0, '0);

    // Two windows back to back with in_valid held high throughout.
    for (int k = 0; k < 2 * BEATS + ROWS; k++) tick(1'b1, rnd64());
    for (int i = 0; i < ROWS + 3; i++) tick(1'b0, '0);

    // Random gaps and data.
    for (int k = 0; k < 2 * BEATS + 60; k++) tick(($urandom_range(0, 2) != 0), rnd64());
    for (int i = 0; i < ROWS + 3; i++) tick(1'b0, '0);

    // Partial fill abandoned by reset.
    for (int k = 0; k < 40; k++) tick(1'b1, rnd64());
    do_reset();

    // Fill, then reset while row 10 is on the output.
    for (int k = 0; k < BEATS; k++) tick(1'b1, rnd64());
    for (int i = 0; i < 10; i++) tick(1'b0, '0);
    do_reset();
    for (int k = 0; k < BEATS + 1; k++) tick(1'b1, rnd64());
    for (int i = 0; i < ROWS + 3; i++) tick(1'b0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
